alu_issue_decoder: RTL and testbench
====================================

// Module: alu_issue_decoder
// PURPOSE
//  Front end that drives the 32-bit ALU: decodes RV32I OP/OP-IMM/LUI/AUIPC (+ Zbb ROL) into ALU opcode + operands.
//  Sits between the register-read stage (upstream) and the ALU (downstream); fully registered valid/ready outputs.
//  Unsupported encodings pass through flagged illegal and are counted.
// PARAMETERS
//  CNT_W     16  width of saturating illegal-instruction counter
//  EN_ROL    1   1: decode Zbb ROL (OP, funct7=0110000, funct3=001) to ALU ROL; 0: treat as illegal
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      reset, asynchronous, active-high
//  flush          in   1      synchronous: drop all buffered entries
//  in_valid       in   1      upstream entry valid
//  in_ready       out  1      registered; 1 when skid entry empty
//  in_instr       in   32     instruction word
//  in_pc          in   32     instruction PC (AUIPC operand)
//  in_rs1_data    in   32     rs1 value
//  in_rs2_data    in   32     rs2 value
//  out_valid      out  1      ALU-side entry valid
//  out_ready      in   1      ALU side accepts entry
//  out_alu_op     out  4      ALU opcode (alu_op_t)
//  out_a          out  32     ALU operand A
//  out_b          out  32     ALU operand B
//  out_rd         out  5      destination register
//  out_rd_we      out  1      write enable (0 if illegal or rd==0)
//  out_illegal    out  1      entry decoded illegal
//  illegal_count  out  CNT_W  illegal entries accepted since reset, saturating
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, illegal_count=0; out_alu_op/out_a/out_b/out_rd/out_rd_we/out_illegal=0.
//  Handshake: transfer when valid&ready same edge; out_* stable while out_valid&!out_ready.
//  Buffer: output reg + 1 skid reg. Accept into output reg if empty or draining, else into skid.
//   in_ready next = skid empty after update. Latency 1 cycle; throughput 1/cycle with out_ready=1.
//   Order strictly preserved; skid drains into output reg on the cycle output is consumed.
//  Decode (alu_op encoding: ADD=1 SUB=2 AND=3 OR=4 XOR=5 NOT=6 SLL=7 SRL=8 SRA=9 ROL=10):
//   OP   f7=0000000: f3 000 ADD,111 AND,110 OR,100 XOR,001 SLL,101 SRL; f7=0100000: f3 000 SUB,101 SRA; a=rs1,b=rs2
//   OP-IMM: ADDI/ANDI/ORI/XORI -> ADD/AND/OR/XOR, b=sign-ext imm[11:0]; XORI with imm==0xFFF -> NOT (b=0xFFFFFFFF)
//   SLLI(f7=0000000) SRLI(f7=0000000) SRAI(f7=0100000): b={27'b0,shamt}; other f7 illegal
//   LUI: ADD, a=0, b={imm[31:12],12'b0}; AUIPC: ADD, a=in_pc, b={imm[31:12],12'b0}
//   ROL (EN_ROL=1): a=rs1, b=rs2
//   Anything else (SLT/SLTU/SLTI/SLTIU, loads, branches, bad funct7, low bits!=11): alu_op=0, a=b=0,
//    out_illegal=1, out_rd_we=0; still transferred in order
//  Counter: +1 on each accepted illegal entry; holds at all-ones.
//  flush: output and skid cleared (out_valid=0, in_ready=1 next cycle); an in handshake in a flush cycle is
//   discarded and not counted; flush has priority over accept and drain; counter unaffected.
//  Async rst mid-transfer: all entries lost, no partial state.
// STRUCTURE
//  Package alu_pkg: alu_op_t enum (values above, shared with ALU), RV opcode/funct3/funct7 localparams,
//   decoded-entry struct {alu_op,a,b,rd,rd_we,illegal}.
//  Combinational decode function in this module; sub-module alu_issue_skid (param width, 2-entry valid/ready
//   skid buffer with flush) holds decoded structs.
// TESTING
//  ADDI x1,x2,-1 (0xFFF10093), rs1=5 -> next cycle out_alu_op=1, a=5, b=0xFFFFFFFF, rd=1, rd_we=1.
//  XORI x3,x4,-1 (0xFFF24193) -> alu_op=6 (NOT); SUB x5,x6,x7 (0x407302B3) -> alu_op=2, a=rs1, b=rs2.
//  LUI x1,0x12345 (0x123450B7) -> alu_op=1, a=0, b=0x12345000; AUIPC same imm, pc=0x100 -> a=0x100.
//  SLT x0,x1,x2 (0x0020A033) -> out_illegal=1, alu_op=0, rd_we=0, illegal_count 0->1.
//  Back-to-back 3 entries, out_ready=0 2 cycles -> in_ready low after 2nd, all 3 emerge in order, no loss.
//  Two buffered entries + flush with in_valid=1 -> out_valid=0, in_ready=1 next cycle, counter unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode enum, RV32I decode constants and decoded-entry struct
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_NOT  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_ROL  = 4'd10
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_ROT  = 7'b0110000;

    typedef struct packed {
        alu_op_t     alu_op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } alu_entry_t;

endpackage

// File: rtl/alu_issue_skid.sv
// rtl/alu_issue_skid.sv - two-entry valid/ready skid buffer (output reg + skid reg) with flush
module alu_issue_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         in_ready_q, in_ready_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         accept, drain;

    always_comb begin
        accept       = in_valid && in_ready_q;
        drain        = out_valid_q && out_ready;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            // in_ready is low whenever skid holds data, so skid and accept never collide
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) out_data_d = in_data;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/alu_issue_decoder.sv
// rtl/alu_issue_decoder.sv - decodes RV32I OP/OP-IMM/LUI/AUIPC (+ROL) into ALU op and operands
module alu_issue_decoder
    import alu_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int EN_ROL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_rs1_data,
    input  logic [31:0]      in_rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_alu_op,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [4:0]       out_rd,
    output logic             out_rd_we,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    function automatic alu_entry_t decode(input logic [31:0] instr, input logic [31:0] pc,
                                          input logic [31:0] rs1, input logic [31:0] rs2);
        alu_entry_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        f3       = instr[14:12];
        f7       = instr[31:25];
        e        = '0;
        e.alu_op = ALU_NONE;
        e.rd     = instr[11:7];
        case (instr[6:0])
            OPC_OP: begin
                e.a = rs1;
                e.b = rs2;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  e.alu_op = ALU_ADD;
                        F3_AND:  e.alu_op = ALU_AND;
                        F3_OR:   e.alu_op = ALU_OR;
                        F3_XOR:  e.alu_op = ALU_XOR;
                        F3_SLL:  e.alu_op = ALU_SLL;
                        F3_SR:   e.alu_op = ALU_SRL;
                        default: e.alu_op = ALU_NONE;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    e.alu_op = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == F3_SR) begin
                    e.alu_op = ALU_SRA;
                end else if (EN_ROL != 0 && f7 == F7_ROT && f3 == F3_SLL) begin
                    e.alu_op = ALU_ROL;
                end
            end
            OPC_OP_IMM: begin
                e.a = rs1;
                e.b = {{20{instr[31]}}, instr[31:20]};
                case (f3)
                    F3_ADD: e.alu_op = ALU_ADD;
                    F3_AND: e.alu_op = ALU_AND;
                    F3_OR:  e.alu_op = ALU_OR;
                    F3_XOR: e.alu_op = (instr[31:20] == 12'hFFF) ? ALU_NOT : ALU_XOR;
                    F3_SLL: begin
                        e.b = {27'b0, instr[24:20]};
                        if (f7 == F7_BASE) e.alu_op = ALU_SLL;
                    end
                    F3_SR: begin
                        e.b = {27'b0, instr[24:20]};
                        if (f7 == F7_BASE)     e.alu_op = ALU_SRL;
                        else if (f7 == F7_ALT) e.alu_op = ALU_SRA;
                    end
                    default: e.alu_op = ALU_NONE;
                endcase
            end
            OPC_LUI: begin
                e.alu_op = ALU_ADD;
                e.b      = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                e.alu_op = ALU_ADD;
                e.a      = pc;
                e.b      = {instr[31:12], 12'b0};
            end
            default: e.alu_op = ALU_NONE;
        endcase
        // Anything left undecoded travels down the pipe as an inert, flagged entry
        if (e.alu_op == ALU_NONE) begin
            e.a       = '0;
            e.b       = '0;
            e.illegal = 1'b1;
        end
        e.rd_we = !e.illegal && (e.rd != 5'd0);
        return e;
    endfunction

    alu_entry_t       dec_entry, out_entry;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign dec_entry = decode(in_instr, in_pc, in_rs1_data, in_rs2_data);

    alu_issue_skid #(.W($bits(alu_entry_t))) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && in_ready && !flush && dec_entry.illegal && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign out_alu_op    = out_entry.alu_op;
    assign out_a         = out_entry.a;
    assign out_b         = out_entry.b;
    assign out_rd        = out_entry.rd;
    assign out_rd_we     = out_entry.rd_we;
    assign out_illegal   = out_entry.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// tb/tb_alu_issue_decoder.sv - table-driven decode vectors plus ordering, flush, saturation and reset sequences
module tb_alu_issue_decoder;

    localparam int CNT_W = 4;

    logic             clk, rst, flush;
    logic             in_valid, in_ready;
    logic [31:0]      in_instr, in_pc, in_rs1_data, in_rs2_data;
    logic             out_valid, out_ready;
    logic [3:0]       out_alu_op;
    logic [31:0]      out_a, out_b;
    logic [4:0]       out_rd;
    logic             out_rd_we, out_illegal;
    logic [CNT_W-1:0] illegal_count;

    int n_cmp = 0;
    int n_err = 0;

    alu_issue_decoder #(.CNT_W(CNT_W), .EN_ROL(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_op    (out_alu_op),
        .out_a         (out_a),
        .out_b         (out_b),
        .out_rd        (out_rd),
        .out_rd_we     (out_rd_we),
        .out_illegal   (out_illegal),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, pc, rs1, rs2;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic        we, ill;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        int sent, got;
        logic [4:0] rd_act;

        vecs[0]  = '{32'hFFF10093, 32'h0, 32'h5,        32'h7,    4'd1,  32'h5,        32'hFFFFFFFF, 5'd1, 1'b1, 1'b0};
        vecs[1]  = '{32'hFFF24193, 32'h0, 32'h1234,     32'h0,    4'd6,  32'h1234,     32'hFFFFFFFF, 5'd3, 1'b1, 1'b0};
        vecs[2]  = '{32'h407302B3, 32'h0, 32'd10,       32'd3,    4'd2,  32'd10,       32'd3,        5'd5, 1'b1, 1'b0};
        vecs[3]  = '{32'h123450B7, 32'h0, 32'hDEAD,     32'hBEEF, 4'd1,  32'h0,        32'h12345000, 5'd1, 1'b1, 1'b0};
        vecs[4]  = '{32'h12345097, 32'h100, 32'hDEAD,   32'hBEEF, 4'd1,  32'h100,      32'h12345000, 5'd1, 1'b1, 1'b0};
        vecs[5]  = '{32'h0020A033, 32'h0, 32'h11,       32'h22,   4'd0,  32'h0,        32'h0,        5'd0, 1'b0, 1'b1};
        vecs[6]  = '{32'h00208033, 32'h0, 32'h11,       32'h22,   4'd1,  32'h11,       32'h22,       5'd0, 1'b0, 1'b0};
        vecs[7]  = '{32'h60839333, 32'h0, 32'h80000001, 32'h1,    4'd10, 32'h80000001, 32'h1,        5'd6, 1'b1, 1'b0};
        vecs[8]  = '{32'h4051D113, 32'h0, 32'hF0,       32'h0,    4'd9,  32'hF0,       32'h5,        5'd2, 1'b1, 1'b0};
        vecs[9]  = '{32'h40109093, 32'h0, 32'h1,        32'h1,    4'd0,  32'h0,        32'h0,        5'd1, 1'b0, 1'b1};
        vecs[10] = '{32'h7FF0F093, 32'h0, 32'h1234,     32'h0,    4'd3,  32'h1234,     32'h7FF,      5'd1, 1'b1, 1'b0};
        vecs[11] = '{32'h00208031, 32'h0, 32'h11,       32'h22,   4'd0,  32'h0,        32'h0,        5'd0, 1'b0, 1'b1};
        vecs[12] = '{32'h003150B3, 32'h0, 32'h80,       32'h3,    4'd8,  32'h80,       32'h3,        5'd1, 1'b1, 1'b0};
        vecs[13] = '{32'h0062E233, 32'h0, 32'h5,        32'h6,    4'd4,  32'h5,        32'h6,        5'd4, 1'b1, 1'b0};
        vecs[14] = '{32'h00F0C093, 32'h0, 32'hAA,       32'h0,    4'd5,  32'hAA,       32'hF,        5'd1, 1'b1, 1'b0};

        clk = 0; rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        in_instr = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_count", illegal_count, 0);
        check("reset_fields", {out_alu_op, out_a, out_b, out_rd, out_rd_we, out_illegal}, 0);
        rst = 0;
        @(posedge clk);
        #1;

        out_ready = 1;
        exp_cnt = 0;
        for (int i = 0; i < NV; i++) begin
            push(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            if (vecs[i].ill) exp_cnt++;
            rd_act = vecs[i].ill ? vecs[i].rd : out_rd;
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_fields", i),
                  {out_alu_op, out_a, out_b, rd_act, out_rd_we, out_illegal},
                  {vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].we, vecs[i].ill});
            check($sformatf("vec%0d_count", i), illegal_count, exp_cnt);
        end
        @(posedge clk);
        #1;
        check("idle_after_table", out_valid, 0);

        // Three back-to-back entries with the ALU stalled for two cycles
        sent = 0; got = 0;
        for (int c = 0; c < 30 && got < 3; c++) begin
            in_valid    = (sent < 3);
            in_instr    = 32'h002080B3;
            in_rs1_data = 100 + sent;
            in_rs2_data = sent;
            out_ready   = (c >= 3);
            @(negedge clk);
            if (c == 2) check("order_in_ready_low", in_ready, 0);
            if (out_valid && out_ready) begin
                check($sformatf("order_entry%0d", got), out_a, 100 + got);
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        check("order_all_received", got, 3);
        @(posedge clk);
        #1;
        check("order_drained", out_valid, 0);

        // Flush with both registers full and an illegal entry offered
        out_ready = 0;
        push(32'h002080B3, 0, 1, 1);
        push(32'h002080B3, 0, 2, 2);
        check("flushA_full", in_ready, 0);
        flush = 1; in_valid = 1; in_instr = 32'h0020A033;
        @(posedge clk);
        #1;
        flush = 0; in_valid = 0;
        check("flushA_out_valid", out_valid, 0);
        check("flushA_in_ready", in_ready, 1);
        check("flushA_count", illegal_count, exp_cnt);

        // Flush with skid empty, so the offered illegal entry would otherwise be accepted
        push(32'h002080B3, 0, 3, 3);
        flush = 1; in_valid = 1; in_instr = 32'h0020A033;
        @(posedge clk);
        #1;
        flush = 0; in_valid = 0;
        check("flushB_out_valid", out_valid, 0);
        check("flushB_count", illegal_count, exp_cnt);
        out_ready = 1;
        push(32'h002080B3, 0, 32'h77, 0);
        check("post_flush_valid", out_valid, 1);
        check("post_flush_a", out_a, 32'h77);
        @(posedge clk);
        #1;
        check("post_flush_no_stale", out_valid, 0);

        for (int i = 0; i < 14; i++) begin
            push(32'h0020A033, 0, 0, 0);
            if (exp_cnt < 15) exp_cnt++;
            check($sformatf("sat_count%0d", i), illegal_count, exp_cnt);
        end

        // Async reset in the middle of a cycle with entries buffered
        out_ready = 0;
        push(32'h002080B3, 0, 9, 9);
        push(32'h002080B3, 0, 8, 8);
        #3;
        rst = 1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_count", illegal_count, 0);
        @(posedge clk);
        #1;
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
